// File: rtl/uart_rx_deframer_if.sv
// Byte handshake between the UART receiver and its consumer.
//   rx_data  : received byte, stable while rx_valid is high
//   rx_valid : a byte is waiting; held until the consumer acknowledges it
//   rx_ack   : consumer has taken rx_data
// master = receiver side (drives data/valid), slave = consumer side (drives ack).
interface uart_rx_deframer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART 8N1 receiver. Synchronizes rx_line, finds the start edge, samples every bit
// mid-period using a runtime bit period, and hands each byte out on a valid/ack handshake.
// Ports:
//   clk          system clock
//   resetn       asynchronous active-low reset
//   rx_line      asynchronous serial input, idles high
//   bit_period   clk cycles per serial bit (4..1023), latched at frame start
//   rx_busy      high whenever a frame is in progress (state != idle)
//   framing_err  1-cycle pulse when the stop bit is sampled low
//   overrun      1-cycle pulse when a byte lands on top of an unacknowledged one
//   bus          byte handshake (rx_data / rx_valid / rx_ack)
module uart_rx_deframer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       rx_line,
    input  logic [9:0]                 bit_period,
    output logic                       rx_busy,
    output logic                       framing_err,
    output logic                       overrun,
    uart_rx_deframer_if.master         bus
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_line;
    logic [9:0]             cnt_q;
    logic [9:0]             per_q;
    logic [2:0]             idx_q;
    logic [7:0]             shift_q;
    logic [7:0]             data_q;
    logic                   valid_q;
    logic [9:0]             half_m1;
    logic [9:0]             per_m1;

    // Synchronizer resets high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_line};
        end
    end

    assign s_line  = sync_q[SYNC_STAGES-1];
    assign half_m1 = (per_q >> 1) - 10'd1;
    assign per_m1  = per_q - 10'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            per_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            framing_err <= 1'b0;
            overrun     <= 1'b0;

            if (bus.rx_ack && valid_q) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (!s_line) begin
                        per_q   <= bit_period;
                        cnt_q   <= '0;
                        state_q <= StStart;
                    end
                end

                // Half a period in: confirm the start bit is still low (glitch filter).
                StStart: begin
                    if (cnt_q == half_m1) begin
                        if (!s_line) begin
                            cnt_q   <= '0;
                            idx_q   <= '0;
                            state_q <= StData;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end

                // LSB arrives first, so shift in from the top.
                StData: begin
                    if (cnt_q == per_m1) begin
                        shift_q <= {s_line, shift_q[7:1]};
                        cnt_q   <= '0;
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end

                StStop: begin
                    if (cnt_q == per_m1) begin
                        cnt_q <= '0;
                        if (s_line) begin
                            // Overrides any ack-clear above: a coincident ack consumes the
                            // old byte and the new one stays valid.
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            overrun <= valid_q & ~bus.rx_ack;
                            state_q <= StIdle;
                        end else begin
                            framing_err <= 1'b1;
                            state_q     <= StBreak;
                        end
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end

                // Line held low after a bad stop bit: wait for idle before re-arming.
                StBreak: begin
                    if (s_line) begin
                        state_q <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign rx_busy      = (state_q != StIdle);
    assign bus.rx_data  = data_q;
    assign bus.rx_valid = valid_q;

endmodule
